seed_buffer: RTL and testbench
==============================

Name: seed_buffer

Overview:
- Downstream of the DoG extremum comparator.
- Captures every flagged extremum address (`valid_max`/`addr_max`) during a frame into an on-chip RAM.
- On the comparator's end-of-scan pulse (`cpr_end`), drains the stored seeds in arrival order over a valid/ready stream to the descriptor/orientation stage.
- Supplies per-seed row/column split, a frame seed count and an overflow flag.

Parameters:
- WIDE, 256, image width in pixels; must be a power of two.
- HIGN, 256, image height in pixels.
- CNT_DW, 16, address width; log2(WIDE*HIGN).
- DEPTH, 512, seed RAM entries; power of two, at most 2^9.
- IDX_W, 9, log2(DEPTH).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- valid_max  in  1  one-cycle strobe: `addr_max` is a keypoint.
- addr_max  in  CNT_DW  linear pixel address, row*WIDE+col.
- cpr_end  in  1  one-cycle pulse: comparator scan of frame finished.
- seed_valid  out  1  output seed valid.
- seed_ready  in  1  consumer accepts seed.
- seed_addr  out  CNT_DW  stored linear address.
- seed_row  out  CNT_DW-log2(WIDE)  `addr[CNT_DW-1:log2(WIDE)]`.
- seed_col  out  log2(WIDE)  `addr[log2(WIDE)-1:0]`.
- seed_idx  out  IDX_W  index of presented seed, 0-based.
- seed_last  out  1  presented seed is final of frame.
- seed_total  out  IDX_W+1  seeds stored this frame; saturates at DEPTH.
- overflow  out  1  sticky per frame: at least one seed dropped.
- frame_done  out  1  one-cycle pulse when drain complete.
- busy  out  1  high in DRAIN state.

Behaviour:
- Reset (rst=1 at posedge):
  - state=COLLECT; write pointer and read pointer = 0.
  - All outputs 0: `seed_valid`, `seed_addr`, `seed_row`, `seed_col`, `seed_idx`, `seed_last`, `seed_total`, `overflow`, `frame_done`, `busy`.
  - Reset mid-drain abandons the frame; no `frame_done`.
- COLLECT:
  - `valid_max`=1 and `seed_total`<DEPTH: write `addr_max` at wr_ptr; wr_ptr++ and `seed_total`++.
  - `valid_max`=1 and `seed_total`==DEPTH: no write; `overflow`<=1.
  - `cpr_end` with `valid_max` in the same cycle: the seed is stored first, then the transition is taken.
  - `cpr_end` with `seed_total`==0 (after any same-cycle write): `frame_done` pulses next cycle; stay in COLLECT; clear `overflow` the cycle after `frame_done`.
  - Otherwise, `cpr_end`: state=DRAIN next cycle.
- DRAIN:
  - RAM read is registered.
  - First `seed_valid`=1 exactly 2 cycles after the `cpr_end` cycle, presenting entry 0.
  - While `seed_valid`=1 and `seed_ready`=0, all seed_* outputs hold stable.
  - Transfer = `seed_valid`&`seed_ready` at posedge. After a transfer of entry k<total-1, entry k+1 is presented in the next cycle: full throughput, one seed per cycle with `seed_ready` held high; needs a prefetch register.
  - `seed_last`=1 only with `seed_idx`==`seed_total`-1.
  - After the last transfer:
    - `seed_valid`=0 next cycle; `frame_done`=1 for one cycle that cycle.
    - state=COLLECT; pointers=0.
    - `seed_total` and `overflow` cleared the cycle after `frame_done`, so the consumer can sample them alongside `frame_done`.
  - `valid_max` in DRAIN: dropped; sets `overflow` for the current frame (no storage).
  - `cpr_end` in DRAIN: ignored.
- `busy`=1 exactly while state=DRAIN.
- Arithmetic:
  - `seed_row`/`seed_col` are pure bit slices of the registered `seed_addr`, so there is no extra latency.
  - Pointers wrap never: bounded by DEPTH.

Test Plan:
1. Reset, 3 seeds, full-rate drain. Pulse `valid_max` with addr 0x1234, 0x2020, 0x3005; `cpr_end` at cycle T; `seed_ready`=1.
   - `seed_valid` at T+2,T+3,T+4 with addr 0x1234/0x2020/0x3005, row 0x12/0x20/0x30, col 0x34/0x20/0x05, idx 0/1/2.
   - `seed_last` only on idx2; `frame_done` at T+5; `seed_total`=3 during drain; `overflow`=0.
2. Backpressure. Same 3 seeds; `seed_ready` low for 4 cycles after `seed_valid` rises, then toggles 1,0,1,1.
   - Outputs stable while stalled; every seed delivered exactly once in order; `frame_done` one cycle after the final transfer.
3. Overflow. DEPTH+5 `valid_max` strobes, then `cpr_end`.
   - `seed_total`=DEPTH and `overflow`=1 sampled at `frame_done`; exactly DEPTH seeds drained (the first DEPTH); both cleared the cycle after `frame_done`.
4. Empty frame / simultaneous events.
   - `cpr_end` with no seeds: `frame_done` next cycle; `seed_valid` never rises.
   - `valid_max`(0x00FF) and `cpr_end` in the same cycle: one seed 0x00FF drained with `seed_last`=1.
5. Strobes during drain and mid-drain reset.
   - `valid_max` in DRAIN: `overflow`=1; that addr never output.
   - `rst`=1 mid-drain: next cycle all outputs 0, state COLLECT; a new 1-seed frame then drains correctly with idx 0.

Source files
------------

// File: rtl/seed_buffer.sv
// Seed buffer: stores DoG extremum addresses during a frame and replays them
// in arrival order over a valid/ready stream once the comparator scan ends.
module seed_buffer #(
   parameter int WIDE   = 256,
   parameter int HIGN   = 256,
   parameter int CNT_DW = 16,
   parameter int DEPTH  = 512,
   parameter int IDX_W  = 9
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           valid_max,
   input  logic [CNT_DW-1:0]              addr_max,
   input  logic                           cpr_end,
   output logic                           seed_valid,
   input  logic                           seed_ready,
   output logic [CNT_DW-1:0]              seed_addr,
   output logic [CNT_DW-$clog2(WIDE)-1:0] seed_row,
   output logic [$clog2(WIDE)-1:0]        seed_col,
   output logic [IDX_W-1:0]               seed_idx,
   output logic                           seed_last,
   output logic [IDX_W:0]                 seed_total,
   output logic                           overflow,
   output logic                           frame_done,
   output logic                           busy
);

   localparam int              COL_W   = $clog2(WIDE);
   localparam logic [IDX_W:0]  L_DEPTH = (IDX_W+1)'(DEPTH);
   localparam logic [IDX_W:0]  L_ONE   = (IDX_W+1)'(1);

   if (WIDE * HIGN != (1 << CNT_DW)) begin : g_bad_dims
      $error("seed_buffer: WIDE*HIGN must equal 2**CNT_DW");
   end
   if (DEPTH != (1 << IDX_W)) begin : g_bad_depth
      $error("seed_buffer: DEPTH must equal 2**IDX_W");
   end

   typedef enum logic {
      S_COLLECT = 1'b0,
      S_DRAIN   = 1'b1
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;

   logic [CNT_DW-1:0]   r_mem [DEPTH];

   logic [IDX_W:0]      r_total;
   logic                r_overflow;
   logic                r_frame_done;
   logic [IDX_W:0]      r_rd_ptr;

   // Presented seed (output stage)
   logic                r_valid;
   logic [CNT_DW-1:0]   r_addr;
   logic [IDX_W-1:0]    r_idx;
   logic                r_last;

   // Prefetch stage: absorbs the read issued in the cycle a stall begins
   logic                r_pf_valid;
   logic [CNT_DW-1:0]   r_pf_addr;
   logic [IDX_W-1:0]    r_pf_idx;
   logic                r_pf_last;

   logic [IDX_W:0]      w_total_base;
   logic                w_ovf_base;
   logic [IDX_W:0]      w_total_nxt;
   logic [IDX_W-1:0]    w_wr_ptr;
   logic                w_wr_en;
   logic                w_drop;
   logic                w_done;
   logic                w_xfer;
   logic                w_out_free;
   logic                w_can_rd;
   logic [CNT_DW-1:0]   w_rd_addr;
   logic                w_rd_last;

   // The frame_done cycle is already the first cycle of the next frame, so
   // count and overflow are treated as cleared there while still being shown.
   assign w_total_base = r_frame_done ? '0 : r_total;
   assign w_ovf_base   = r_frame_done ? 1'b0 : r_overflow;
   assign w_wr_ptr     = w_total_base[IDX_W-1:0];

   assign w_xfer       = r_valid & seed_ready;
   assign w_out_free   = ~r_valid | w_xfer;
   assign w_can_rd     = (r_rd_ptr < r_total);
   assign w_rd_addr    = r_mem[r_rd_ptr[IDX_W-1:0]];
   assign w_rd_last    = (r_rd_ptr == r_total - L_ONE);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_COLLECT;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      // NOTE: every output of this block gets a default first so no path leaves one unassigned (no latch).
      w_state_nxt = r_state;
      w_wr_en     = 1'b0;
      w_drop      = 1'b0;
      w_done      = 1'b0;
      w_total_nxt = w_total_base;

      unique case (r_state)
         S_COLLECT: begin
            if (valid_max) begin
               if (w_total_base < L_DEPTH) begin
                  w_wr_en     = 1'b1;
                  w_total_nxt = w_total_base + L_ONE;
               end else begin
                  w_drop = 1'b1;
               end
            end
            if (cpr_end) begin
               if (w_total_nxt == '0) begin
                  w_done = 1'b1;
               end else begin
                  w_state_nxt = S_DRAIN;
               end
            end
         end
         S_DRAIN: begin
            w_drop = valid_max;
            if (w_xfer && r_last) begin
               w_done      = 1'b1;
               w_state_nxt = S_COLLECT;
            end
         end
         default: w_state_nxt = S_COLLECT;
      endcase
   end

   // NOTE: the seed RAM is deliberately not reset; entries are only read below r_total.
   always_ff @(posedge clk) begin
      if (w_wr_en) begin
         r_mem[w_wr_ptr] <= addr_max;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_total      <= '0;
         r_overflow   <= 1'b0;
         r_frame_done <= 1'b0;
      end else begin
         r_total      <= w_total_nxt;
         r_overflow   <= w_ovf_base | w_drop;
         r_frame_done <= w_done;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_rd_ptr   <= '0;
         r_valid    <= 1'b0;
         r_addr     <= '0;
         r_idx      <= '0;
         r_last     <= 1'b0;
         r_pf_valid <= 1'b0;
         r_pf_addr  <= '0;
         r_pf_idx   <= '0;
         r_pf_last  <= 1'b0;
      end else if (w_done || r_state != S_DRAIN) begin
         r_rd_ptr   <= '0;
         r_valid    <= 1'b0;
         r_pf_valid <= 1'b0;
      end else if (w_out_free) begin
         if (r_pf_valid) begin
            r_valid <= 1'b1;
            r_addr  <= r_pf_addr;
            r_idx   <= r_pf_idx;
            r_last  <= r_pf_last;
            if (w_can_rd) begin
               r_pf_addr <= w_rd_addr;
               r_pf_idx  <= r_rd_ptr[IDX_W-1:0];
               r_pf_last <= w_rd_last;
               r_rd_ptr  <= r_rd_ptr + L_ONE;
            end else begin
               r_pf_valid <= 1'b0;
            end
         end else if (w_can_rd) begin
            r_valid  <= 1'b1;
            r_addr   <= w_rd_addr;
            r_idx    <= r_rd_ptr[IDX_W-1:0];
            r_last   <= w_rd_last;
            r_rd_ptr <= r_rd_ptr + L_ONE;
         end else begin
            r_valid <= 1'b0;
         end
      end else if (!r_pf_valid && w_can_rd) begin
         r_pf_valid <= 1'b1;
         r_pf_addr  <= w_rd_addr;
         r_pf_idx   <= r_rd_ptr[IDX_W-1:0];
         r_pf_last  <= w_rd_last;
         r_rd_ptr   <= r_rd_ptr + L_ONE;
      end
   end

   assign seed_valid = r_valid;
   assign seed_addr  = r_addr;
   assign seed_row   = r_addr[CNT_DW-1:COL_W];
   assign seed_col   = r_addr[COL_W-1:0];
   assign seed_idx   = r_idx;
   assign seed_last  = r_last;
   assign seed_total = r_total;
   assign overflow   = r_overflow;
   assign frame_done = r_frame_done;
   assign busy       = (r_state == S_DRAIN);

endmodule

// File: tb/tb_seed_buffer.sv
// Self-checking bench for seed_buffer: directed scenarios plus random frames
// scored against a queue model of the stored seeds.
module tb_seed_buffer;

   localparam int WIDE   = 256;
   localparam int HIGN   = 256;
   localparam int CNT_DW = 16;
   localparam int DEPTH  = 512;
   localparam int IDX_W  = 9;
   localparam int COL_W  = 8;
   localparam int ROW_W  = CNT_DW - COL_W;

   logic              clk;
   logic              rst;
   logic              valid_max;
   logic [CNT_DW-1:0] addr_max;
   logic              cpr_end;
   logic              seed_valid;
   logic              seed_ready;
   logic [CNT_DW-1:0] seed_addr;
   logic [ROW_W-1:0]  seed_row;
   logic [COL_W-1:0]  seed_col;
   logic [IDX_W-1:0]  seed_idx;
   logic              seed_last;
   logic [IDX_W:0]    seed_total;
   logic              overflow;
   logic              frame_done;
   logic              busy;

   int n_total = 0;
   int n_bad   = 0;

   logic [CNT_DW-1:0] exp_q[$];
   bit                exp_ovf = 1'b0;
   bit                pat [8] = '{0, 0, 0, 0, 1, 0, 1, 1};

   seed_buffer #(
      .WIDE(WIDE), .HIGN(HIGN), .CNT_DW(CNT_DW), .DEPTH(DEPTH), .IDX_W(IDX_W)
   ) dut (
      .clk(clk), .rst(rst), .valid_max(valid_max), .addr_max(addr_max),
      .cpr_end(cpr_end), .seed_valid(seed_valid), .seed_ready(seed_ready),
      .seed_addr(seed_addr), .seed_row(seed_row), .seed_col(seed_col),
      .seed_idx(seed_idx), .seed_last(seed_last), .seed_total(seed_total),
      .overflow(overflow), .frame_done(frame_done), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [63:0] all_outs();
      return 64'({seed_valid, seed_addr, seed_row, seed_col, seed_idx,
                  seed_last, seed_total, overflow, frame_done, busy});
   endfunction

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   // Stores into the model exactly what an unlimited-capacity-up-to-DEPTH RAM would keep.
   task automatic model_push(input logic [CNT_DW-1:0] a);
      if (exp_q.size() < DEPTH) exp_q.push_back(a);
      else exp_ovf = 1'b1;
   endtask

   task automatic push_seed(input logic [CNT_DW-1:0] a);
      valid_max = 1'b1;
      addr_max  = a;
      model_push(a);
      cycle();
      valid_max = 1'b0;
   endtask

   task automatic drain(input int rdy_mode, input int strobe_at, input string tag);
      int n, k, cyc, budget;
      bit done, stalled, rdy, xfer;
      logic [CNT_DW+IDX_W:0] prev_s;
      logic [CNT_DW-1:0] ea;
      n = exp_q.size();
      k = 0; cyc = 0; done = 0; stalled = 0; budget = 8 * n + 40;
      prev_s = '0;
      n_total++;
      if ({seed_valid, busy, frame_done} !== 3'b010) begin
         n_bad++;
         $display("FAIL %s drain_start: valid/busy/done=%b%b%b want 010", tag, seed_valid, busy, frame_done);
      end
      seed_ready = 1'b0;
      cycle();
      while (!done && cyc < budget) begin
         n_total++;
         if (seed_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL %s seed_valid cyc=%0d: got %b want 1", tag, cyc, seed_valid);
         end
         if (seed_valid === 1'b1) begin
            ea = exp_q[k];
            n_total++;
            if ({seed_addr, seed_row, seed_col} !== {ea, ROW_W'(ea / WIDE), COL_W'(ea % WIDE)}) begin
               n_bad++;
               $display("FAIL %s addr k=%0d: got %h/%h/%h want %h/%h/%h", tag, k,
                        seed_addr, seed_row, seed_col, ea, ROW_W'(ea / WIDE), COL_W'(ea % WIDE));
            end
            n_total++;
            if ({seed_idx, seed_last, seed_total} !== {IDX_W'(k), (k == n - 1), (IDX_W+1)'(n)}) begin
               n_bad++;
               $display("FAIL %s idx/last/total k=%0d: got %0d/%b/%0d want %0d/%b/%0d", tag, k,
                        seed_idx, seed_last, seed_total, k, (k == n - 1), n);
            end
            if (stalled) begin
               n_total++;
               if ({seed_addr, seed_idx, seed_last} !== prev_s) begin
                  n_bad++;
                  $display("FAIL %s stall_hold k=%0d: got %h want %h", tag, k,
                           {seed_addr, seed_idx, seed_last}, prev_s);
               end
            end
         end
         n_total++;
         if (frame_done !== 1'b0) begin
            n_bad++;
            $display("FAIL %s early_frame_done cyc=%0d: got %b want 0", tag, cyc, frame_done);
         end
         case (rdy_mode)
            0:       rdy = 1'b1;
            1:       rdy = (cyc < 8) ? pat[cyc] : 1'b1;
            default: rdy = ($urandom_range(0, 3) != 0);
         endcase
         seed_ready = rdy;
         if (cyc == strobe_at) begin
            valid_max = 1'b1;
            addr_max  = 16'hBEEF;
            exp_ovf   = 1'b1;
         end
         xfer    = (seed_valid === 1'b1) && rdy;
         stalled = (seed_valid === 1'b1) && !rdy;
         prev_s  = {seed_addr, seed_idx, seed_last};
         cycle();
         valid_max = 1'b0;
         cyc++;
         if (xfer) begin
            k++;
            if (k == n) done = 1;
         end
      end
      n_total++;
      if (!done) begin
         n_bad++;
         $display("FAIL %s drain_timeout: delivered %0d want %0d", tag, k, n);
      end
      if (rdy_mode == 0) begin
         n_total++;
         if (cyc != n) begin
            n_bad++;
            $display("FAIL %s throughput: cycles %0d want %0d", tag, cyc, n);
         end
      end
      n_total++;
      if ({seed_valid, frame_done, seed_total, overflow} !== {1'b0, 1'b1, (IDX_W+1)'(n), exp_ovf}) begin
         n_bad++;
         $display("FAIL %s frame_done_state: valid/done/total/ovf=%b/%b/%0d/%b want 0/1/%0d/%b",
                  tag, seed_valid, frame_done, seed_total, overflow, n, exp_ovf);
      end
      seed_ready = 1'b0;
      cycle();
      n_total++;
      if ({frame_done, seed_total, overflow, busy, seed_valid} !== '0) begin
         n_bad++;
         $display("FAIL %s post_clear: done/total/ovf/busy/valid=%b/%0d/%b/%b/%b want all 0",
                  tag, frame_done, seed_total, overflow, busy, seed_valid);
      end
      exp_q.delete();
      exp_ovf = 1'b0;
   endtask

   task automatic frame_end(input bit with_seed, input logic [CNT_DW-1:0] a,
                            input int rdy_mode, input int strobe_at, input string tag);
      cpr_end = 1'b1;
      if (with_seed) begin
         valid_max = 1'b1;
         addr_max  = a;
         model_push(a);
      end
      cycle();
      cpr_end   = 1'b0;
      valid_max = 1'b0;
      if (exp_q.size() == 0) begin
         n_total++;
         if ({frame_done, busy, seed_valid} !== 3'b100) begin
            n_bad++;
            $display("FAIL %s empty_done: done/busy/valid=%b%b%b want 100", tag, frame_done, busy, seed_valid);
         end
         cycle();
         n_total++;
         if ({frame_done, busy, seed_valid, overflow} !== 4'b0000) begin
            n_bad++;
            $display("FAIL %s empty_after: done/busy/valid/ovf=%b%b%b%b want 0000", tag,
                     frame_done, busy, seed_valid, overflow);
         end
         exp_ovf = 1'b0;
      end else begin
         drain(rdy_mode, strobe_at, tag);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; valid_max = 1'b0; addr_max = '0; cpr_end = 1'b0; seed_ready = 1'b0;
      cycle();
      cycle();
      n_total++;
      if (all_outs() !== 64'd0) begin
         n_bad++;
         $display("FAIL reset_outputs: got %h want 0", all_outs());
      end
      rst = 1'b0;
      cycle();
      n_total++;
      if (all_outs() !== 64'd0) begin
         n_bad++;
         $display("FAIL reset_idle: got %h want 0", all_outs());
      end
   endtask

   task automatic test_full_rate();
      push_seed(16'h1234);
      push_seed(16'h2020);
      push_seed(16'h3005);
      n_total++;
      if (seed_total !== 10'd3 || busy !== 1'b0) begin
         n_bad++;
         $display("FAIL collect_total: got %0d busy %b want 3 busy 0", seed_total, busy);
      end
      frame_end(1'b0, '0, 0, -1, "full_rate");
   endtask

   task automatic test_backpressure();
      push_seed(16'h1234);
      push_seed(16'h2020);
      push_seed(16'h3005);
      frame_end(1'b0, '0, 1, -1, "backpressure");
   endtask

   task automatic test_overflow();
      for (int i = 0; i < DEPTH + 5; i++) push_seed(16'((i * 37 + 11) & 16'hFFFF));
      n_total++;
      if (seed_total !== 10'(DEPTH) || overflow !== 1'b1) begin
         n_bad++;
         $display("FAIL overflow_collect: total %0d ovf %b want %0d 1", seed_total, overflow, DEPTH);
      end
      frame_end(1'b0, '0, 0, -1, "overflow");
   endtask

   task automatic test_empty_and_simul();
      frame_end(1'b0, '0, 0, -1, "empty");
      for (int i = 0; i < 4; i++) begin
         n_total++;
         if (seed_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL empty_no_valid cyc=%0d: got %b want 0", i, seed_valid);
         end
         cycle();
      end
      frame_end(1'b1, 16'h00FF, 0, -1, "simul");
   endtask

   task automatic test_drain_strobe_and_reset();
      push_seed(16'h0101);
      push_seed(16'h0202);
      push_seed(16'h0303);
      frame_end(1'b0, '0, 0, 1, "drain_strobe");
      push_seed(16'h0A0A);
      push_seed(16'h0B0B);
      push_seed(16'h0C0C);
      push_seed(16'h0D0D);
      cpr_end = 1'b1;
      cycle();
      cpr_end    = 1'b0;
      seed_ready = 1'b1;
      cycle();
      n_total++;
      if (seed_valid !== 1'b1 || seed_addr !== 16'h0A0A || seed_idx !== 9'd0) begin
         n_bad++;
         $display("FAIL prereset_first: valid %b addr %h idx %0d want 1 0a0a 0", seed_valid, seed_addr, seed_idx);
      end
      cycle();
      rst = 1'b1;
      seed_ready = 1'b0;
      cycle();
      rst = 1'b0;
      n_total++;
      if (all_outs() !== 64'd0) begin
         n_bad++;
         $display("FAIL midreset_outputs: got %h want 0", all_outs());
      end
      exp_q.delete();
      exp_ovf = 1'b0;
      for (int i = 0; i < 3; i++) begin
         cycle();
         n_total++;
         if ({frame_done, seed_valid, busy} !== 3'b000) begin
            n_bad++;
            $display("FAIL midreset_quiet cyc=%0d: done/valid/busy=%b%b%b want 000", i, frame_done, seed_valid, busy);
         end
      end
      push_seed(16'h4321);
      frame_end(1'b0, '0, 0, -1, "post_reset");
   endtask

   task automatic test_random();
      int n, strobe;
      bit simul;
      for (int f = 0; f < 8; f++) begin
         n = $urandom_range(0, 24);
         for (int i = 0; i < n; i++) begin
            push_seed(16'($urandom));
            repeat ($urandom_range(0, 2)) cycle();
         end
         simul  = ($urandom_range(0, 2) == 0);
         strobe = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 4)) : -1;
         frame_end(simul, 16'($urandom), 2, strobe, "random");
         repeat ($urandom_range(0, 3)) cycle();
      end
   endtask

   initial begin
      test_reset();
      test_full_rate();
      test_backpressure();
      test_overflow();
      test_empty_and_simul();
      test_drain_strobe_and_reset();
      test_random();
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
